// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer run controller: FSM state codes and
// timer mode constants used by the controller, clock mux and end-value logic.
package timer_ctrl_pkg;

   localparam int unsigned StateWidth = 3;

   typedef enum logic [StateWidth-1:0] {
      StIdle  = 3'd0,
      StRun   = 3'd1,
      StPause = 3'd2,
      StAlarm = 3'd3,
      StHold  = 3'd4
   } ctrl_state_e;

   localparam logic MODE_STOPWATCH = 1'b0;
   localparam logic MODE_TIMER     = 1'b1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a slow board switch, asynchronously reset to 0.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/timer_run_controller.sv
// Run-state sequencer for the two-mode timer: turns the StartStop/ModeSel switches
// into run enable, clear pulse and latched mode, and drives the alarm and DOT patterns.
module timer_run_controller
   import timer_ctrl_pkg::*;
#(
   parameter int unsigned PAUSE_TIMEOUT = 30,
   parameter int unsigned ALARM_SECS    = 5
) (
   input  logic                  CLK_1Hz,
   input  logic                  rst_n,
   input  logic                  start_stop,
   input  logic                  mode_sel,
   input  logic                  core_done,
   output logic                  run_en,
   output logic                  core_clr,
   output logic                  mode_active,
   output logic                  dot,
   output logic                  alarm,
   output logic [StateWidth-1:0] state
);

   localparam int unsigned PauseCntW = $clog2(PAUSE_TIMEOUT + 1);
   localparam int unsigned AlarmCntW = $clog2(ALARM_SECS + 1);
   localparam logic [PauseCntW-1:0] PauseLast = PauseCntW'(PAUSE_TIMEOUT - 1);
   localparam logic [AlarmCntW-1:0] AlarmInit = AlarmCntW'(ALARM_SECS - 1);

   logic ss_s, md_s;

   ctrl_state_e          state_q, state_d;
   logic                 mode_q, mode_d;
   logic                 run_q, run_d;
   logic                 clr_q, clr_d;
   logic                 dot_q, dot_d;
   logic                 alarm_q, alarm_d;
   logic [PauseCntW-1:0] pause_cnt_q, pause_cnt_d;
   logic [AlarmCntW-1:0] alarm_cnt_q, alarm_cnt_d;

   sync2 u_sync_ss (
      .clk   (CLK_1Hz),
      .rst_n (rst_n),
      .d     (start_stop),
      .q     (ss_s)
   );

   sync2 u_sync_md (
      .clk   (CLK_1Hz),
      .rst_n (rst_n),
      .d     (mode_sel),
      .q     (md_s)
   );

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      clr_d       = 1'b0;
      pause_cnt_d = pause_cnt_q;
      alarm_cnt_d = alarm_cnt_q;

      // A mode change outside IDLE aborts whatever is in progress.
      if (state_q != StIdle && md_s != mode_q) begin
         state_d = StIdle;
         mode_d  = md_s;
         clr_d   = 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               mode_d = md_s;
               if (ss_s) state_d = StRun;
            end
            StRun: begin
               if (core_done) begin
                  state_d     = StAlarm;
                  alarm_cnt_d = AlarmInit;
               end else if (!ss_s) begin
                  state_d     = StPause;
                  pause_cnt_d = '0;
               end
            end
            StPause: begin
               if (ss_s) begin
                  state_d = StRun;
               end else if (pause_cnt_q == PauseLast) begin
                  state_d = StIdle;
                  clr_d   = 1'b1;
               end else begin
                  pause_cnt_d = pause_cnt_q + PauseCntW'(1);
               end
            end
            StAlarm: begin
               if (alarm_cnt_q == '0) state_d = StHold;
               else                   alarm_cnt_d = alarm_cnt_q - AlarmCntW'(1);
            end
            StHold: begin
               if (!ss_s) begin
                  state_d = StIdle;
                  clr_d   = 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               clr_d   = 1'b1;
            end
         endcase
      end
   end

   // Outputs are registered alongside the state, so they follow state_d.
   always_comb begin
      run_d = (state_d == StRun);

      case (state_d)
         StRun:           dot_d = (state_q == StRun) ? ~dot_q : dot_q;
         StPause:         dot_d = dot_q;
         StAlarm, StHold: dot_d = 1'b1;
         default:         dot_d = 1'b0;
      endcase

      if (state_d == StAlarm) alarm_d = (state_q == StAlarm) ? ~alarm_q : 1'b1;
      else                    alarm_d = 1'b0;
   end

   always_ff @(posedge CLK_1Hz or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         mode_q      <= MODE_STOPWATCH;
         run_q       <= 1'b0;
         clr_q       <= 1'b0;
         dot_q       <= 1'b0;
         alarm_q     <= 1'b0;
         pause_cnt_q <= '0;
         alarm_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         run_q       <= run_d;
         clr_q       <= clr_d;
         dot_q       <= dot_d;
         alarm_q     <= alarm_d;
         pause_cnt_q <= pause_cnt_d;
         alarm_cnt_q <= alarm_cnt_d;
      end
   end

   assign state       = state_q;
   assign mode_active = mode_q;
   assign run_en      = run_q;
   assign core_clr    = clr_q;
   assign dot         = dot_q;
   assign alarm       = alarm_q;

endmodule

// File: tb/tb_timer_run_controller.sv
// Directed table-driven bench for timer_run_controller with default parameters
// (PAUSE_TIMEOUT=30, ALARM_SECS=5); one table row per clock edge.
module tb_timer_run_controller;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_PAUSE = 3'd2;
   localparam logic [2:0] S_ALARM = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;

   logic       clk;
   logic       rst_n;
   logic       start_stop;
   logic       mode_sel;
   logic       core_done;
   logic       run_en;
   logic       core_clr;
   logic       mode_active;
   logic       dot;
   logic       alarm;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       ss;
      logic       md;
      logic       done;
      logic [2:0] st;
      logic       run;
      logic       clr;
      logic       mode;
      logic       dt;
      logic       alm;
   } vec_t;

   vec_t tbl[$];

   timer_run_controller #(
      .PAUSE_TIMEOUT (30),
      .ALARM_SECS    (5)
   ) dut (
      .CLK_1Hz     (clk),
      .rst_n       (rst_n),
      .start_stop  (start_stop),
      .mode_sel    (mode_sel),
      .core_done   (core_done),
      .run_en      (run_en),
      .core_clr    (core_clr),
      .mode_active (mode_active),
      .dot         (dot),
      .alarm       (alarm),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(input logic ss, input logic md, input logic done,
                               input logic [2:0] st, input logic run, input logic clr,
                               input logic mode, input logic dt, input logic alm);
      vec_t v;
      v.ss = ss; v.md = md; v.done = done;
      v.st = st; v.run = run; v.clr = clr; v.mode = mode; v.dt = dt; v.alm = alm;
      tbl.push_back(v);
   endfunction

   task automatic check(input string name, input logic [2:0] st, input logic run,
                        input logic clr, input logic mode, input logic dt, input logic alm);
      logic [7:0] got, exp;
      got = {state, run_en, core_clr, mode_active, dot, alarm};
      exp = {st, run, clr, mode, dt, alm};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got state=%0d run_en=%b core_clr=%b mode=%b dot=%b alarm=%b, want state=%0d run_en=%b core_clr=%b mode=%b dot=%b alarm=%b",
                  name, state, run_en, core_clr, mode_active, dot, alarm,
                  st, run, clr, mode, dt, alm);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Start, run, drop switch, pause times out (edges 1..40).
      for (int i = 0; i < 2; i++) add(1, 0, 0, S_IDLE, 0, 0, 0, 0, 0);
      add(1, 0, 0, S_RUN, 1, 0, 0, 0, 0);
      add(1, 0, 0, S_RUN, 1, 0, 0, 1, 0);
      add(1, 0, 0, S_RUN, 1, 0, 0, 0, 0);
      add(1, 0, 0, S_RUN, 1, 0, 0, 1, 0);
      add(0, 0, 0, S_RUN, 1, 0, 0, 0, 0);
      add(0, 0, 0, S_RUN, 1, 0, 0, 1, 0);
      for (int i = 0; i < 30; i++) add(0, 0, 0, S_PAUSE, 0, 0, 0, 1, 0);
      add(0, 0, 0, S_IDLE, 0, 1, 0, 0, 0);
      add(0, 0, 0, S_IDLE, 0, 0, 0, 0, 0);
      // Short pause then resume; dot frozen then toggles again.
      add(1, 0, 0, S_IDLE, 0, 0, 0, 0, 0);
      add(1, 0, 0, S_IDLE, 0, 0, 0, 0, 0);
      add(1, 0, 0, S_RUN, 1, 0, 0, 0, 0);
      add(1, 0, 0, S_RUN, 1, 0, 0, 1, 0);
      add(0, 0, 0, S_RUN, 1, 0, 0, 0, 0);
      add(0, 0, 0, S_RUN, 1, 0, 0, 1, 0);
      add(1, 0, 0, S_PAUSE, 0, 0, 0, 1, 0);
      add(1, 0, 0, S_PAUSE, 0, 0, 0, 1, 0);
      add(1, 0, 0, S_RUN, 1, 0, 0, 1, 0);
      add(1, 0, 0, S_RUN, 1, 0, 0, 0, 0);
      // core_done: alarm 1,0,1,0,1 then HOLD until the switch is lowered.
      add(1, 0, 1, S_ALARM, 0, 0, 0, 1, 1);
      add(1, 0, 1, S_ALARM, 0, 0, 0, 1, 0);
      add(1, 0, 1, S_ALARM, 0, 0, 0, 1, 1);
      add(1, 0, 1, S_ALARM, 0, 0, 0, 1, 0);
      add(1, 0, 1, S_ALARM, 0, 0, 0, 1, 1);
      add(1, 0, 1, S_HOLD, 0, 0, 0, 1, 0);
      add(1, 0, 0, S_HOLD, 0, 0, 0, 1, 0);
      add(0, 0, 0, S_HOLD, 0, 0, 0, 1, 0);
      add(0, 0, 0, S_HOLD, 0, 0, 0, 1, 0);
      add(0, 0, 0, S_IDLE, 0, 1, 0, 0, 0);
      add(0, 0, 0, S_IDLE, 0, 0, 0, 0, 0);
      // core_done together with synced StartStop falling: done wins.
      add(1, 0, 0, S_IDLE, 0, 0, 0, 0, 0);
      add(1, 0, 0, S_IDLE, 0, 0, 0, 0, 0);
      add(1, 0, 0, S_RUN, 1, 0, 0, 0, 0);
      add(0, 0, 0, S_RUN, 1, 0, 0, 1, 0);
      add(0, 0, 0, S_RUN, 1, 0, 0, 0, 0);
      add(0, 0, 1, S_ALARM, 0, 0, 0, 1, 1);
      // Mode change mid-ALARM aborts to IDLE, alarm drops on the same edge.
      add(0, 1, 0, S_ALARM, 0, 0, 0, 1, 0);
      add(0, 1, 0, S_ALARM, 0, 0, 0, 1, 1);
      add(0, 1, 0, S_IDLE, 0, 1, 1, 0, 0);
      add(0, 1, 0, S_IDLE, 0, 0, 1, 0, 0);
      // Mode change in IDLE: mode follows, no clear.
      add(0, 0, 0, S_IDLE, 0, 0, 1, 0, 0);
      add(0, 0, 0, S_IDLE, 0, 0, 1, 0, 0);
      add(0, 0, 0, S_IDLE, 0, 0, 0, 0, 0);
      // Mode change in RUN: single clear, then immediate restart in new mode.
      add(1, 0, 0, S_IDLE, 0, 0, 0, 0, 0);
      add(1, 0, 0, S_IDLE, 0, 0, 0, 0, 0);
      add(1, 0, 0, S_RUN, 1, 0, 0, 0, 0);
      add(1, 1, 0, S_RUN, 1, 0, 0, 1, 0);
      add(1, 1, 0, S_RUN, 1, 0, 0, 0, 0);
      add(1, 1, 0, S_IDLE, 0, 1, 1, 0, 0);
      add(1, 1, 0, S_RUN, 1, 0, 1, 0, 0);
      add(1, 1, 0, S_RUN, 1, 0, 1, 1, 0);

      rst_n      = 1'b0;
      start_stop = 1'b0;
      mode_sel   = 1'b0;
      core_done  = 1'b0;
      #2;
      check("reset", S_IDLE, 0, 0, 0, 0, 0);
      #6;
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         start_stop = tbl[i].ss;
         mode_sel   = tbl[i].md;
         core_done  = tbl[i].done;
         step();
         check($sformatf("row%0d", i), tbl[i].st, tbl[i].run, tbl[i].clr,
               tbl[i].mode, tbl[i].dt, tbl[i].alm);
      end

      // Asynchronous reset in the middle of ALARM.
      core_done = 1'b1;
      step();
      check("enter_alarm", S_ALARM, 0, 0, 1, 1, 1);
      step();
      check("alarm_2nd", S_ALARM, 0, 0, 1, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", S_IDLE, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("reset_held", S_IDLE, 0, 0, 0, 0, 0);
      rst_n     = 1'b1;
      core_done = 1'b0;
      step();
      check("post_rst_e1", S_IDLE, 0, 0, 0, 0, 0);
      step();
      check("post_rst_e2", S_IDLE, 0, 0, 0, 0, 0);
      step();
      check("post_rst_e3", S_RUN, 1, 0, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/timer_run_controller.md
Name: timer_run_controller

Overview:
- Run-state sequencer for the two-mode timer (10 s stopwatch / 2 min timer), clocked from the 1 Hz divider output.
- Synchronises the StartStop and ModeSel switches and turns them into clean control for the timer core: run enable, clear pulse and latched mode.
- Sequences end-of-count alarm, pause auto-timeout and the DOT pattern.
- Sits between the board switches and the timer core / clock mux. The core and the seven-segment encoder consume its outputs instead of the raw switches.

Parameters:
PAUSE_TIMEOUT, 30, cycles (seconds) in PAUSE before automatic return to IDLE with clear; legal range 1..255
ALARM_SECS, 5, cycles (seconds) the alarm output toggles after core_done; legal range 1..255

Ports:
CLK_1Hz  input  1  controller clock
rst_n  input  1  asynchronous, active-low reset
start_stop  input  1  raw StartStop switch level; 1 = run requested
mode_sel  input  1  raw ModeSel switch; 0 = stopwatch, 1 = timer
core_done  input  1  timer core at end value (MSB==msb_end && LSB==lsb_end), level
run_en  output  1  timer core count enable
core_clr  output  1  one-cycle synchronous clear pulse to timer core
mode_active  output  1  latched mode driving the clock mux and end-value selection
dot  output  1  decimal-point drive
alarm  output  1  end-of-count alarm drive
state  output  3  current FSM state, for debug and bench

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; sync flops, counters, run_en, core_clr, mode_active, dot and alarm all 0.
  - Release is sampled on the next CLK_1Hz rising edge.
- Input sync:
  - start_stop and mode_sel each pass through a 2-flop synchroniser: ss_s, md_s.
  - A change present before edge k is visible in ss_s/md_s after edge k+1 and acts on state at edge k+2.
- State encoding: IDLE=0, RUN=1, PAUSE=2, ALARM=3, HOLD=4. Codes 5-7 are illegal and recover to IDLE with a core_clr pulse.
- Transitions, evaluated each edge, listed in priority order:
  1. md_s != mode_active in a state other than IDLE -> IDLE. mode_active<=md_s and core_clr pulses.
  2. In IDLE, mode_active<=md_s every cycle with no clear. If ss_s=1 -> RUN.
  3. RUN: core_done=1 -> ALARM, alarm_cnt<=ALARM_SECS-1. Otherwise ss_s=0 -> PAUSE, pause_cnt<=0.
  4. PAUSE: ss_s=1 -> RUN. Otherwise pause_cnt==PAUSE_TIMEOUT-1 -> IDLE with core_clr pulse. Otherwise pause_cnt++.
  5. ALARM: alarm_cnt==0 -> HOLD. Otherwise alarm_cnt--.
  6. HOLD: ss_s=0 -> IDLE with core_clr pulse. The start_stop switch must be lowered before a new run can begin.
- Outputs (all registered, updated on the same edge as state):
  - run_en=1 only while in RUN.
  - core_clr is high for exactly one cycle following each clearing transition, never two consecutive cycles.
  - dot:
    - RUN: toggles every cycle.
    - PAUSE: holds its last value.
    - IDLE: 0.
    - ALARM and HOLD: 1 steady.
  - alarm:
    - ALARM: toggles every cycle, starting at 1 on entry.
    - All other states: 0.
- Counter widths: $clog2(param+1) bits; counters never wrap.
- Simultaneous events:
  - core_done and ss_s falling in the same cycle -> ALARM (done wins).
  - Mode change during ALARM -> IDLE; alarm drops to 0 on the same edge.
- core_done seen outside RUN is ignored.

Decomposition:
- Package timer_ctrl_pkg holds:
  - the state enum/localparams (IDLE..HOLD, width 3);
  - the MODE_STOPWATCH=0 / MODE_TIMER=1 constants, shared with the clock mux and end-value logic.
- Sub-module sync2: a 2-flop synchroniser with async active-low reset to 0. It is instantiated twice.

Test Plan:
- Reset, then start_stop=1 from cycle 0 -> state=RUN and run_en=1 after edge 2; dot toggles 1,0,1,... from edge 3.
- Running, then start_stop=0 for 30 cycles (PAUSE_TIMEOUT=30) -> PAUSE at edge +2; IDLE plus a single core_clr pulse 30 cycles later; dot frozen during PAUSE.
- Running, then core_done=1 at cycle 10 -> ALARM at the next edge; alarm toggles 1,0,1,0,1 for 5 cycles; then HOLD with alarm=0 and dot=1; lowering start_stop returns to IDLE with a core_clr pulse.
- RUN with mode_sel flipped 0->1 -> after 2 sync cycles: state=IDLE, mode_active=1, core_clr high for 1 cycle, run_en=0.
- IDLE with mode_sel toggled and start_stop held at 0 -> mode_active follows after 2 cycles; no core_clr pulse.
- rst_n asserted mid-ALARM -> all outputs 0 immediately (asynchronous), without waiting for a clock edge; state=IDLE.
